// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port data memory; round-robin, or fixed priority with ARB_FIXED_PRIO_EN.
// Latency: REQ sampled in IDLE -> one ACCESS cycle -> registered ACK pulse; 3 cycles per access.
// Backpressure: one access at a time; a losing or re-raised REQ simply waits for the next IDLE.
module mem_arbiter #(
   parameter int SIZE = 32
) (
   input  logic            CLK,
   input  logic            RST_n,
   input  logic            REQ0,
   input  logic            REQ1,
   input  logic            WE0,
   input  logic            WE1,
   input  logic [SIZE-1:0] ADDR0,
   input  logic [SIZE-1:0] ADDR1,
   input  logic [SIZE-1:0] WDATA0,
   input  logic [SIZE-1:0] WDATA1,
   output logic            ACK0,
   output logic            ACK1,
   output logic [SIZE-1:0] RDATA0,
   output logic [SIZE-1:0] RDATA1,
   output logic            MEM_WE,
   output logic [SIZE-1:0] MEM_ADDR,
   output logic [SIZE-1:0] MEM_DIN,
   input  logic [SIZE-1:0] MEM_DOUT
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   gnt, gnt_nxt;
   logic   last_gnt, last_gnt_nxt;
   logic   winner;
   logic   gnt_we;

`ifdef ARB_FIXED_PRIO_EN
   // last_gnt is still tracked so both builds share the same state register.
   always_comb begin
      winner = ~REQ0;
   end
`else
   always_comb begin
      winner = (REQ0 & REQ1) ? ~last_gnt : REQ1;
   end
`endif

   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      last_gnt_nxt = last_gnt;
      case (state)
         IDLE: begin
            if (REQ0 | REQ1) begin
               state_nxt    = ACCESS;
               gnt_nxt      = winner;
               last_gnt_nxt = winner;
            end
         end
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state    <= IDLE;
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         last_gnt <= last_gnt_nxt;
      end
   end

   // Driven only from registered state and held request inputs, so stable across the negedge.
   assign gnt_we   = gnt ? WE1 : WE0;
   assign MEM_WE   = (state == ACCESS) & gnt_we;
   assign MEM_ADDR = gnt ? ADDR1 : ADDR0;
   assign MEM_DIN  = gnt ? WDATA1 : WDATA0;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         ACK0   <= 1'b0;
         ACK1   <= 1'b0;
         RDATA0 <= '0;
         RDATA1 <= '0;
      end else begin
         ACK0 <= (state == ACCESS) & ~gnt;
         ACK1 <= (state == ACCESS) & gnt;
         if ((state == ACCESS) && !gnt_we) begin
            if (gnt) RDATA1 <= MEM_DOUT;
            else     RDATA0 <= MEM_DOUT;
         end
      end
   end

endmodule
